keccak_arbiter: RTL and testbench
=================================

// Module: keccak_arbiter
// PURPOSE
//  Round-robin scheduler that shares one keccak core among NREQ Kyber hash clients (G, H, XOF, PRF).
//  Grants one whole job at a time: latches mode/lengths, steers the requester's 64b input stream to the core,
//  captures the core digest, and returns a one-cycle done pulse to the owner. Sits between Kyber top FSM and keccak.
// PARAMETERS
//  NREQ       4       number of requesters (2..8)
//  BW_CTRL    2       keccak mode width
//  BW_OBYTES  6272    digest bus width (784 B max output)
//  BW_ILEN    11      input byte-length width (max 1184 B)
//  BW_OLEN    10      output byte-length width
// PORTS
//  i_clk              in   1                clock, rising edge
//  i_rstn             in   1                reset, asynchronous, active-low
//  i_req              in   NREQ             job request, held high by client until its o_done
//  i_req_mode         in   NREQ*BW_CTRL     per-client mode, slice k = client k
//  i_req_ibyte_len    in   NREQ*BW_ILEN     per-client input length, bytes
//  i_req_obyte_len    in   NREQ*BW_OLEN     per-client output length, bytes
//  i_req_ibytes       in   NREQ*64          per-client input beat, MSB-first
//  i_req_ibytes_valid in   NREQ             per-client beat valid
//  o_req_ibytes_ready out  NREQ             per-client beat ready (only granted bit may be 1)
//  o_gnt              out  NREQ             one-hot owner of core, 0 when idle
//  o_done             out  NREQ             one-cycle pulse to owner; o_obytes valid in same cycle
//  o_obytes           out  BW_OBYTES        captured digest, held until next capture
//  o_busy             out  1                core owned
//  o_k_mode           out  BW_CTRL          to core i_mode
//  o_k_ibyte_len      out  BW_ILEN          to core i_ibyte_len
//  o_k_obyte_len      out  BW_OLEN          to core i_obyte_len
//  o_k_ibytes         out  64               to core i_ibytes
//  o_k_ibytes_valid   out  1                to core i_ibytes_valid
//  i_k_ibytes_ready   in   1                from core o_ibytes_ready
//  i_k_obytes         in   BW_OBYTES        from core o_obytes
//  i_k_obytes_valid   in   1                from core o_obytes_valid
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, all outputs 0 (o_gnt, o_done, o_obytes, o_k_* included).
//  FSM IDLE -> RUN -> DONE -> DRAIN -> IDLE.
//  IDLE : if |i_req and i_k_obytes_valid==0: pick first requester at/after pointer (cyclic); at edge set o_gnt
//         one-hot, latch mode/ilen/olen of winner into o_k_*, clear beat counter, go RUN. Latency req->gnt = 1 cycle.
//  RUN  : o_k_ibytes = granted slice; o_k_ibytes_valid = i_req_ibytes_valid[g] & (beats < NBEAT);
//         o_req_ibytes_ready[g] = i_k_ibytes_ready & (beats < NBEAT); NBEAT = ceil(ibyte_len/8).
//         beats++ on valid&ready. Beats beyond NBEAT are not forwarded (ready held 0). o_k_mode/len stable.
//         First cycle with i_k_obytes_valid=1: capture i_k_obytes into o_obytes, go DONE.
//  DONE : o_done[g]=1 for exactly this cycle; pointer <= (g+1) mod NREQ; o_gnt cleared at exit; go DRAIN.
//  DRAIN: wait until i_k_obytes_valid==0 (multi-cycle valid yields one done only), then IDLE; o_k_ibytes_valid=0.
//  Ungranted clients: ready 0, done 0, beats ignored. i_req dropped during RUN: ignored, job completes.
//  Simultaneous requests: round-robin; winner moves to lowest priority after its DONE. No starvation:
//  any held request is granted within NREQ jobs.
//  ibyte_len==0: NBEAT=0, no beats forwarded; job completes on core valid as normal.
//  Reset mid-job: immediate return to IDLE, grant and capture lost, pointer 0; client must re-request.
//  o_busy = (state != IDLE). All control outputs registered except ready/valid/data steering (comb. in RUN).
// STRUCTURE
//  Shared keccak_pkg: mode encodings (SHA3_256=0, SHA3_512=1, SHAKE128=2, SHAKE256=3), BW_ILEN/BW_OLEN,
//  max byte constants (1184 in, 784 out), FSM state encoding.
//  Sub-module rr_arbiter (combinational: req + pointer -> one-hot grant, NREQ param); rest in this file.
// TESTING
//  1 Single req[2], SHA3_256, ilen=32, olen=32 -> gnt=0100 next cycle, 4 beats forwarded, one done[2], o_obytes==vector.
//  2 req=1111 held from reset -> grant order 0,1,2,3,0; each done is one pulse; no beat leaks to ungranted client.
//  3 Client 1 holds valid after 4 beats with ilen=32 -> 5th beat not forwarded, ready[1]=0, job still completes.
//  4 Core holds obytes_valid 3 cycles -> exactly one done pulse; next grant only after valid falls.
//  5 Core ready toggles 1/0 every cycle, SHAKE128 ilen=34 olen=168 -> 5 beats, data order intact, digest matches.
//  6 i_rstn low mid-RUN -> o_gnt=0, o_k_ibytes_valid=0 immediately; after release held req[3] gets gnt=1000.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared definitions for the Kyber keccak sharing logic: mode encodings,
// length widths, byte limits and the arbiter FSM state encoding.
package keccak_pkg;

  localparam int CTRL_W     = 2;
  localparam int ILEN_W     = 11;
  localparam int OLEN_W     = 10;
  localparam int OBYTES_W   = 6272;
  localparam int IBYTES_MAX = 1184;
  localparam int OBYTES_MAX = 784;

  typedef enum logic [1:0] {
    MODE_SHA3_256 = 2'd0,
    MODE_SHA3_512 = 2'd1,
    MODE_SHAKE128 = 2'd2,
    MODE_SHAKE256 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// searching cyclically. Returns one-hot grant, its index and a found flag.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            any
);

  logic [PW-1:0] idx_s;

  // Cyclic priority scan starting at the pointer
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx_s = PW'((int'(ptr) + i) % NREQ);
      if (!any && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        gnt_idx    = idx_s;
        any        = 1'b1;
      end else begin
      end
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// Shares one keccak core among NREQ hash clients, one whole job at a time,
// with round-robin ownership and a single done pulse per job.
module keccak_arbiter
  import keccak_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int BW_CTRL   = CTRL_W,
  parameter int BW_OBYTES = OBYTES_W,
  parameter int BW_ILEN   = ILEN_W,
  parameter int BW_OLEN   = OLEN_W
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [NREQ-1:0]         i_req,
  input  logic [NREQ*BW_CTRL-1:0] i_req_mode,
  input  logic [NREQ*BW_ILEN-1:0] i_req_ibyte_len,
  input  logic [NREQ*BW_OLEN-1:0] i_req_obyte_len,
  input  logic [NREQ*64-1:0]      i_req_ibytes,
  input  logic [NREQ-1:0]         i_req_ibytes_valid,
  output logic [NREQ-1:0]         o_req_ibytes_ready,
  output logic [NREQ-1:0]         o_gnt,
  output logic [NREQ-1:0]         o_done,
  output logic [BW_OBYTES-1:0]    o_obytes,
  output logic                    o_busy,
  output logic [BW_CTRL-1:0]      o_k_mode,
  output logic [BW_ILEN-1:0]      o_k_ibyte_len,
  output logic [BW_OLEN-1:0]      o_k_obyte_len,
  output logic [63:0]             o_k_ibytes,
  output logic                    o_k_ibytes_valid,
  input  logic                    i_k_ibytes_ready,
  input  logic [BW_OBYTES-1:0]    i_k_obytes,
  input  logic                    i_k_obytes_valid
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e               state_r, state_s;
  logic [NREQ-1:0]      gnt_r, done_r, win_s, ready_s;
  logic [PW-1:0]        gidx_r, ptr_r, win_idx_s, ptr_next_s;
  logic                 win_any_s, start_s, more_s, fire_s, k_valid_s, busy_r;
  logic [BW_ILEN-1:0]   beats_r, nbeat_r, nbeat_s, win_ilen_s, k_ilen_r;
  logic [BW_CTRL-1:0]   k_mode_r;
  logic [BW_OLEN-1:0]   k_olen_r;
  logic [BW_OBYTES-1:0] obytes_r;
  logic [63:0]          k_ibytes_s;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req     (i_req),
    .ptr     (ptr_r),
    .gnt     (win_s),
    .gnt_idx (win_idx_s),
    .any     (win_any_s)
  );

  // A new job may only start once the core has released its previous digest
  assign start_s    = win_any_s & ~i_k_obytes_valid;
  assign win_ilen_s = i_req_ibyte_len[int'(win_idx_s)*BW_ILEN +: BW_ILEN];
  assign nbeat_s    = BW_ILEN'(win_ilen_s >> 2'd3) + BW_ILEN'(|win_ilen_s[2:0]);
  assign ptr_next_s = (gidx_r == PW'(NREQ-1)) ? PW'(0) : gidx_r + PW'(1);
  assign more_s     = (beats_r < nbeat_r);
  assign fire_s     = k_valid_s & i_k_ibytes_ready;

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_r <= ST_IDLE;
    else         state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_s)           state_s = ST_RUN;   else state_s = ST_IDLE;
      ST_RUN:   if (i_k_obytes_valid)  state_s = ST_DONE;  else state_s = ST_RUN;
      ST_DONE:  state_s = ST_DRAIN;
      ST_DRAIN: if (!i_k_obytes_valid) state_s = ST_IDLE;  else state_s = ST_DRAIN;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Steering of the owner's beat stream to the core while running
  always_comb begin
    k_ibytes_s = '0;
    k_valid_s  = 1'b0;
    ready_s    = '0;
    if (state_r == ST_RUN) begin
      k_ibytes_s      = i_req_ibytes[int'(gidx_r)*64 +: 64];
      k_valid_s       = i_req_ibytes_valid[gidx_r] & more_s;
      ready_s[gidx_r] = i_k_ibytes_ready & more_s;
    end else begin
      k_ibytes_s = '0;
    end
  end

  // Registered job context, beat counter, digest capture and handshakes
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      gnt_r    <= '0;
      done_r   <= '0;
      gidx_r   <= '0;
      ptr_r    <= '0;
      beats_r  <= '0;
      nbeat_r  <= '0;
      k_mode_r <= '0;
      k_ilen_r <= '0;
      k_olen_r <= '0;
      obytes_r <= '0;
      busy_r   <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            gnt_r    <= win_s;
            gidx_r   <= win_idx_s;
            k_mode_r <= i_req_mode[int'(win_idx_s)*BW_CTRL +: BW_CTRL];
            k_ilen_r <= win_ilen_s;
            k_olen_r <= i_req_obyte_len[int'(win_idx_s)*BW_OLEN +: BW_OLEN];
            nbeat_r  <= nbeat_s;
            beats_r  <= '0;
          end
        end
        ST_RUN: begin
          if (fire_s) beats_r <= beats_r + BW_ILEN'(1);
          if (i_k_obytes_valid) begin
            obytes_r <= i_k_obytes;
            done_r   <= gnt_r;
          end
        end
        ST_DONE: begin
          done_r <= '0;
          gnt_r  <= '0;
          ptr_r  <= ptr_next_s;
        end
        ST_DRAIN: begin
          done_r <= '0;
        end
        default: begin
          gnt_r  <= '0;
          done_r <= '0;
        end
      endcase
    end
  end

  assign o_req_ibytes_ready = ready_s;
  assign o_gnt              = gnt_r;
  assign o_done             = done_r;
  assign o_obytes           = obytes_r;
  assign o_busy             = busy_r;
  assign o_k_mode           = k_mode_r;
  assign o_k_ibyte_len      = k_ilen_r;
  assign o_k_obyte_len      = k_olen_r;
  assign o_k_ibytes         = k_ibytes_s;
  assign o_k_ibytes_valid   = k_valid_s;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Self-checking bench for keccak_arbiter: directed scenarios plus random jobs,
// checked against a round-robin/client-stream reference model.
module tb_keccak_arbiter;
  import keccak_pkg::*;

  localparam int N  = 4;
  localparam int OW = 6272;

  logic            clk = 1'b0;
  logic            i_rstn;
  logic [N-1:0]    i_req;
  logic [N*2-1:0]  i_req_mode;
  logic [N*11-1:0] i_req_ibyte_len;
  logic [N*10-1:0] i_req_obyte_len;
  logic [N*64-1:0] i_req_ibytes;
  logic [N-1:0]    i_req_ibytes_valid;
  logic [N-1:0]    o_req_ibytes_ready, o_gnt, o_done;
  logic [OW-1:0]   o_obytes, i_k_obytes;
  logic            o_busy, o_k_ibytes_valid, i_k_ibytes_ready, i_k_obytes_valid;
  logic [1:0]      o_k_mode;
  logic [10:0]     o_k_ibyte_len;
  logic [9:0]      o_k_obyte_len;
  logic [63:0]     o_k_ibytes;

  keccak_arbiter dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_req(i_req), .i_req_mode(i_req_mode),
    .i_req_ibyte_len(i_req_ibyte_len), .i_req_obyte_len(i_req_obyte_len),
    .i_req_ibytes(i_req_ibytes), .i_req_ibytes_valid(i_req_ibytes_valid),
    .o_req_ibytes_ready(o_req_ibytes_ready), .o_gnt(o_gnt), .o_done(o_done),
    .o_obytes(o_obytes), .o_busy(o_busy), .o_k_mode(o_k_mode),
    .o_k_ibyte_len(o_k_ibyte_len), .o_k_obyte_len(o_k_obyte_len),
    .o_k_ibytes(o_k_ibytes), .o_k_ibytes_valid(o_k_ibytes_valid),
    .i_k_ibytes_ready(i_k_ibytes_ready), .i_k_obytes(i_k_obytes),
    .i_k_obytes_valid(i_k_obytes_valid)
  );

  always #5 clk = ~clk;

  // Client model: each client streams src[k] from idx[k] up to load_pos[k]
  logic [1:0]  job_mode[N];
  logic [10:0] job_ilen[N];
  logic [9:0]  job_olen[N];
  logic [63:0] src[N][64];
  int          idx[N], load_pos[N], model_pos[N], done_cnt[N];
  bit          hs[N];
  logic [63:0] fwd_q[$];
  int          leak_cnt, nchk, nerr, rr_ptr;
  bit          rdy_toggle, rdy_level;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      i_req_mode[k*2 +: 2]       = job_mode[k];
      i_req_ibyte_len[k*11 +: 11] = job_ilen[k];
      i_req_obyte_len[k*10 +: 10] = job_olen[k];
      i_req_ibytes[k*64 +: 64]   = src[k][idx[k] & 63];
      i_req_ibytes_valid[k]      = (idx[k] < load_pos[k]);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      hs[k] = i_req_ibytes_valid[k] & o_req_ibytes_ready[k];
      if (o_done[k]) done_cnt[k]++;
    end
    if (o_k_ibytes_valid & i_k_ibytes_ready) fwd_q.push_back(o_k_ibytes);
    if (((o_req_ibytes_ready & ~o_gnt) != '0) || ((o_done & ~o_gnt) != '0) || !$onehot0(o_gnt))
      leak_cnt++;
  end

  always @(posedge clk) begin
    #2;
    for (int k = 0; k < N; k++) if (hs[k]) idx[k]++;
    i_k_ibytes_ready = rdy_toggle ? ~i_k_ibytes_ready : rdy_level;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_job(input int k, input int mode, input int ilen, input int olen, input int nbeats);
    job_mode[k] = 2'(mode);
    job_ilen[k] = 11'(ilen);
    job_olen[k] = 10'(olen);
    for (int j = 0; j < nbeats; j++) src[k][(load_pos[k] + j) & 63] = {$urandom, $urandom};
    load_pos[k] += nbeats;
  endtask

  // Core side of one job: expect the round-robin winner, its beats and one done
  task automatic serve(input int vcyc, input bit drop);
    int w, c, nb, dw0, ds0, ds1;
    logic [OW-1:0] dig;
    w = 0;
    for (int i = N - 1; i >= 0; i--) if (i_req[(rr_ptr + i) % N]) w = (rr_ptr + i) % N;
    c = 0;
    while (o_gnt === '0 && c < 100) begin tick(); c++; end
    chk("gnt_wait", 64'(c < 100), 64'd1);
    fwd_q.delete();
    chk("gnt", 64'(o_gnt), 64'(1 << w));
    chk("busy", 64'(o_busy), 64'd1);
    chk("k_mode", 64'(o_k_mode), 64'(job_mode[w]));
    chk("k_ilen", 64'(o_k_ibyte_len), 64'(job_ilen[w]));
    chk("k_olen", 64'(o_k_obyte_len), 64'(job_olen[w]));
    nb = (int'(job_ilen[w]) + 7) / 8;
    c = 0;
    while (fwd_q.size() < nb && c < 200) begin tick(); c++; end
    repeat (3) tick();
    chk("beat_cnt", 64'(fwd_q.size()), 64'(nb));
    for (int j = 0; j < nb && j < fwd_q.size(); j++)
      chk("beat_data", fwd_q[j], src[w][(model_pos[w] + j) & 63]);
    chk("rdy_after_last", 64'(o_req_ibytes_ready), 64'd0);
    chk("kvalid_after_last", 64'(o_k_ibytes_valid), 64'd0);
    model_pos[w] += nb;
    dw0 = done_cnt[w];
    ds0 = 0;
    for (int k = 0; k < N; k++) ds0 += done_cnt[k];
    for (int i = 0; i < OW / 32; i++) dig[i*32 +: 32] = $urandom;
    i_k_obytes = dig;
    i_k_obytes_valid = 1'b1;
    tick();
    chk("done", 64'(o_done), 64'(1 << w));
    nchk++;
    assert (o_obytes === dig) else begin
      nerr++;
      $error("FAIL obytes: observed=%0h expected=%0h", o_obytes[63:0], dig[63:0]);
    end
    for (int i = 1; i < vcyc; i++) begin
      tick();
      chk("done_once", 64'(o_done), 64'd0);
      chk("gnt_in_drain", 64'(o_gnt), 64'd0);
    end
    i_k_obytes_valid = 1'b0;
    if (drop) i_req[w] = 1'b0;
    tick();
    chk("gnt_after_valid", 64'(o_gnt), 64'd0);
    ds1 = 0;
    for (int k = 0; k < N; k++) ds1 += done_cnt[k];
    chk("done_cnt_owner", 64'(done_cnt[w] - dw0), 64'd1);
    chk("done_cnt_total", 64'(ds1 - ds0), 64'd1);
    chk("obytes_hold", o_obytes[63:0], dig[63:0]);
    rr_ptr = (w + 1) % N;
  endtask

  initial begin
    int mask, il, guard;
    i_rstn = 1'b0; i_req = '0; i_k_obytes = '0; i_k_obytes_valid = 1'b0;
    rdy_level = 1'b1; rdy_toggle = 1'b0; rr_ptr = 0;
    for (int k = 0; k < N; k++) begin
      load_pos[k] = 0; model_pos[k] = 0; job_mode[k] = '0; job_ilen[k] = '0; job_olen[k] = '0;
      for (int j = 0; j < 64; j++) src[k][j] = '0;
    end
    repeat (2) tick();
    chk("rst_gnt", 64'(o_gnt), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_k_mode", 64'(o_k_mode), 64'd0);
    chk("rst_k_ilen", 64'(o_k_ibyte_len), 64'd0);
    chk("rst_k_olen", 64'(o_k_obyte_len), 64'd0);
    chk("rst_k_valid", 64'(o_k_ibytes_valid), 64'd0);
    chk("rst_k_ibytes", o_k_ibytes, 64'd0);
    chk("rst_ready", 64'(o_req_ibytes_ready), 64'd0);
    chk("rst_obytes", 64'(o_obytes !== '0), 64'd0);
    i_rstn = 1'b1;
    tick();

    // Single SHA3-256 job on client 2, grant one cycle after request
    load_job(2, MODE_SHA3_256, 32, 32, 4);
    i_req[2] = 1'b1;
    tick();
    chk("gnt_latency", 64'(o_gnt), 64'h4);
    serve(1, 1'b1);

    // All four requesting out of reset: order 0,1,2,3,0
    i_rstn = 1'b0; rr_ptr = 0;
    for (int k = 0; k < N; k++) begin
      il = $urandom_range(1, 40);
      load_job(k, $urandom_range(0, 3), il, $urandom_range(1, 784), (k == 0 ? 2 : 1) * ((il + 7) / 8));
    end
    i_req = 4'b1111;
    tick();
    i_rstn = 1'b1;
    serve(1, 1'b0);
    serve(1, 1'b1);
    serve(2, 1'b1);
    serve(1, 1'b1);
    serve(1, 1'b1);

    // Client 1 offers a fifth beat for a 32-byte job
    load_job(1, MODE_SHA3_512, 32, 64, 5);
    i_req[1] = 1'b1;
    serve(1, 1'b1);

    // Core keeps digest valid 3 cycles while client 0 waits
    load_job(2, MODE_SHAKE256, 16, 32, 2);
    load_job(0, MODE_SHAKE128, 34, 168, 5);
    i_req[2] = 1'b1;
    i_req[0] = 1'b1;
    serve(3, 1'b1);

    // SHAKE128, 34 bytes with core ready toggling every cycle
    rdy_toggle = 1'b1;
    serve(1, 1'b1);
    rdy_toggle = 1'b0;

    // Random job mixes, including zero-length inputs
    for (int it = 0; it < 6; it++) begin
      mask = $urandom_range(1, 15);
      rdy_toggle = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < N; k++) begin
        if (mask[k]) begin
          il = (it == 0) ? 0 : $urandom_range(0, 40);
          load_job(k, $urandom_range(0, 3), il, $urandom_range(1, 784), (il + 7) / 8);
          i_req[k] = 1'b1;
        end
      end
      guard = 0;
      while (i_req != '0 && guard < 8) begin serve($urandom_range(1, 3), 1'b1); guard++; end
    end
    rdy_toggle = 1'b0;

    // Reset in the middle of a job; held request re-granted afterwards
    load_job(3, MODE_SHAKE256, 64, 100, 8);
    i_req[3] = 1'b1;
    guard = 0;
    while (o_gnt === '0 && guard < 100) begin tick(); guard++; end
    chk("mid_gnt", 64'(o_gnt), 64'h8);
    repeat (2) tick();
    i_rstn = 1'b0;
    #1;
    chk("async_rst_gnt", 64'(o_gnt), 64'd0);
    chk("async_rst_kvalid", 64'(o_k_ibytes_valid), 64'd0);
    chk("async_rst_busy", 64'(o_busy), 64'd0);
    tick();
    i_rstn = 1'b1;
    rr_ptr = 0;
    model_pos[3] = idx[3];
    load_job(3, MODE_SHAKE256, 64, 100, 8);
    serve(1, 1'b1);

    chk("no_leak", 64'(leak_cnt), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
